led_vu_meter: RTL and testbench



---
 rtl/led_vu_meter_if.sv | 10 +
 rtl/led_vu_meter.sv | 127 ++++++++++++
 tb/tb_led_vu_meter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_vu_meter_if.sv
// Stereo sample stream from the equalizer core into the level meter.
// One stereo sample is transferred on every cycle valid is high.
interface led_vu_meter_if;
    logic        valid;
    logic [15:0] lft_out;
    logic [15:0] rht_out;

    modport master (output valid, lft_out, rht_out);
    modport slave  (input  valid, lft_out, rht_out);
endinterface

// File: rtl/led_vu_meter.sv
// Stereo peak meter: 3-stage sample pipeline feeding a 6 dB/LED bar or dot display
// with peak hold, stepped decay and a retriggerable clip indicator.
module led_vu_meter #(
    parameter int unsigned HOLD_CYC  = 2500000,
    parameter int unsigned DECAY_CYC = 250000
) (
    input  logic                 clk,
    input  logic                 rst,
    led_vu_meter_if.slave        smp,
    input  logic                 mode,
    output logic [7:0]           LED,
    output logic                 clip
);
    localparam int unsigned CntMax = (HOLD_CYC > DECAY_CYC) ? HOLD_CYC : DECAY_CYC;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] DecayLast = CntW'(DECAY_CYC - 1);

    logic [15:0]     lft_q, rht_q;
    logic            v1_q, v2_q;
    logic [14:0]     mag_q, mag_d;
    logic            sat_q, sat_d;
    logic [3:0]      lvl_q, lvl_d, new_lvl;
    logic [CntW-1:0] hold_q, hold_d, decay_q, decay_d, clip_cnt_q, clip_cnt_d;
    logic            clip_d;
    logic [7:0]      led_d;
    logic [16:0]     lft_ext, rht_ext, lft_abs, rht_abs;
    logic [14:0]     lft_mag, rht_mag;
    logic            upd;

    // abs in 17 bits so -32768 cannot overflow, then clamp to 15 bits
    always_comb begin
        lft_ext = {lft_q[15], lft_q};
        rht_ext = {rht_q[15], rht_q};
        lft_abs = lft_q[15] ? (17'd0 - lft_ext) : lft_ext;
        rht_abs = rht_q[15] ? (17'd0 - rht_ext) : rht_ext;
        lft_mag = (|lft_abs[16:15]) ? 15'h7FFF : lft_abs[14:0];
        rht_mag = (|rht_abs[16:15]) ? 15'h7FFF : rht_abs[14:0];
        mag_d   = (lft_mag > rht_mag) ? lft_mag : rht_mag;
        sat_d   = (lft_q == 16'h7FFF) || (lft_q == 16'h8000) ||
                  (rht_q == 16'h7FFF) || (rht_q == 16'h8000);
    end

    // msb 7 -> level 1 ... msb 14 -> level 8; below 0x80 is level 0
    always_comb begin
        new_lvl = 4'd0;
        for (int i = 7; i < 15; i++) begin
            if (mag_q[i]) new_lvl = 4'(i - 6);
        end
    end

    always_comb begin
        upd     = v2_q && (new_lvl >= lvl_q);
        lvl_d   = lvl_q;
        hold_d  = hold_q;
        decay_d = decay_q;
        if (upd) begin
            lvl_d   = new_lvl;
            hold_d  = HoldLoad;
            decay_d = '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end else if (lvl_q != 4'd0) begin
            if (decay_q == DecayLast) begin
                decay_d = '0;
                lvl_d   = lvl_q - 4'd1;
            end else begin
                decay_d = decay_q + 1'b1;
            end
        end else begin
            decay_d = '0;
        end
    end

    always_comb begin
        clip_d     = clip;
        clip_cnt_d = clip_cnt_q;
        if (v2_q && sat_q) begin
            clip_d     = 1'b1;
            clip_cnt_d = HoldLoad;
        end else if (clip_cnt_q != '0) begin
            clip_cnt_d = clip_cnt_q - 1'b1;
        end else begin
            clip_d = 1'b0;
        end
    end

    always_comb begin
        logic [8:0] bar;
        bar = (9'd1 << lvl_q) - 9'd1;
        if (mode) begin
            led_d = (lvl_q == 4'd0) ? 8'h00 : (8'd1 << (lvl_q - 4'd1));
        end else begin
            led_d = bar[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_q      <= '0;
            rht_q      <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            mag_q      <= '0;
            sat_q      <= 1'b0;
            lvl_q      <= '0;
            hold_q     <= '0;
            decay_q    <= '0;
            clip_cnt_q <= '0;
            clip       <= 1'b0;
            LED        <= '0;
        end else begin
            lft_q      <= smp.lft_out;
            rht_q      <= smp.rht_out;
            v1_q       <= smp.valid;
            v2_q       <= v1_q;
            mag_q      <= mag_d;
            sat_q      <= sat_d;
            lvl_q      <= lvl_d;
            hold_q     <= hold_d;
            decay_q    <= decay_d;
            clip_cnt_q <= clip_cnt_d;
            clip       <= clip_d;
            LED        <= led_d;
        end
    end
endmodule

// File: tb/tb_led_vu_meter.sv
// Randomized scoreboard bench for led_vu_meter: a cycle model built from the
// level/hold/decay rules pushes expected LED/clip, a monitor pops and compares.
module tb_led_vu_meter;
    localparam int unsigned H = 8;
    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic [7:0] LED;
    logic       clip;

    led_vu_meter_if smp();

    led_vu_meter #(.HOLD_CYC(H), .DECAY_CYC(D)) dut (
        .clk  (clk),
        .rst  (rst),
        .smp  (smp),
        .mode (mode),
        .LED  (LED),
        .clip (clip)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; int lvl; bit sat; } samp_t;
    typedef struct { logic [7:0] led; logic clip; } exp_t;

    samp_t pipe[$];
    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    int m_lvl, m_hold, m_decay, m_ccnt;
    bit m_clip;
    bit rst_nx  = 1'b1;
    bit mode_nx = 1'b0;

    function automatic int abs_sat(logic [15:0] x);
        int a;
        a = int'($signed(x));
        if (a < 0) a = -a;
        if (a > 32767) a = 32767;
        return a;
    endfunction

    // Each LED is 6 dB: count halvings until the magnitude falls below 0x80.
    function automatic int level_of(logic [15:0] l, logic [15:0] r);
        int mag, lvl;
        mag = abs_sat(l) > abs_sat(r) ? abs_sat(l) : abs_sat(r);
        lvl = 0;
        while (mag >= 128) begin
            mag = mag / 2;
            lvl++;
        end
        return lvl;
    endfunction

    function automatic logic [7:0] led_pat(int lvl, bit m);
        int v;
        if (m) v = (lvl == 0) ? 0 : (1 << (lvl - 1));
        else   v = (1 << lvl) - 1;
        return 8'(v);
    endfunction

    function automatic bit is_fs(logic [15:0] x);
        return (x == 16'h7FFF) || (x == 16'h8000);
    endfunction

    task automatic model_reset();
        samp_t z;
        z = '{v: 1'b0, lvl: 0, sat: 1'b0};
        m_lvl = 0; m_hold = 0; m_decay = 0; m_ccnt = 0; m_clip = 1'b0;
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
    endtask

    // One clock edge of the reference: a sample affects the level two edges after capture.
    task automatic model_edge();
        exp_t  e;
        samp_t s, n;
        if (rst) begin
            model_reset();
            e = '{led: 8'h00, clip: 1'b0};
            sb.push_back(e);
            return;
        end
        e.led = led_pat(m_lvl, mode);
        s = pipe.pop_front();
        n.v   = smp.valid;
        n.lvl = level_of(smp.lft_out, smp.rht_out);
        n.sat = is_fs(smp.lft_out) || is_fs(smp.rht_out);
        pipe.push_back(n);
        if (s.v && s.lvl >= m_lvl) begin
            m_lvl = s.lvl; m_hold = H - 1; m_decay = 0;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_lvl > 0) begin
            if (m_decay == D - 1) begin
                m_decay = 0; m_lvl--;
            end else begin
                m_decay++;
            end
        end else begin
            m_decay = 0;
        end
        if (s.v && s.sat) begin
            m_clip = 1'b1; m_ccnt = H - 1;
        end else if (m_ccnt > 0) begin
            m_ccnt--;
        end else begin
            m_clip = 1'b0;
        end
        e.clip = m_clip;
        sb.push_back(e);
    endtask

    task automatic check(string name, logic [7:0] act, logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("led", LED, e.led);
                check("clip", {7'd0, clip}, {7'd0, e.clip});
            end
        end
    end

    task automatic step(bit v, logic [15:0] l, logic [15:0] r);
        @(negedge clk);
        rst = rst_nx;
        mode = mode_nx;
        smp.valid = v;
        smp.lft_out = l;
        smp.rht_out = r;
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000);
    endtask

    function automatic logic [15:0] rnd_samp();
        logic [15:0] x;
        case ($urandom_range(0, 11))
            0:       x = 16'h8000;
            1:       x = 16'h7FFF;
            default: begin
                x = 16'($urandom);
                x = x >> $urandom_range(0, 15);
                if ($urandom_range(0, 1) == 1) x = 16'd0 - x;
            end
        endcase
        return x;
    endfunction

    initial begin
        smp.valid = 1'b0;
        smp.lft_out = '0;
        smp.rht_out = '0;
        model_reset();
        idle(3);
        rst_nx = 1'b0;

        // level 2 from +256 / -256
        step(1'b1, 16'h0100, 16'hFF00);
        idle(20);

        // full-scale negative: hold then decay to zero
        step(1'b1, 16'h8000, 16'h0000);
        idle(45);

        // level 8 then continuous level-3 refresh
        step(1'b1, 16'h7FFF, 16'h0000);
        for (int i = 0; i < 60; i++) step(1'b1, 16'h0200, 16'hFE10);
        idle(50);

        // dot mode at level 5, then back to bar
        mode_nx = 1'b1;
        step(1'b1, 16'h0800, 16'h0000);
        idle(4);
        mode_nx = 1'b0;
        idle(25);

        // update landing on the edge a decay step is due
        step(1'b1, 16'h8000, 16'h0000);
        idle(10);
        step(1'b1, 16'h4000, 16'h0000);
        idle(45);

        // asynchronous reset while clipping
        step(1'b1, 16'h8000, 16'h0000);
        idle(3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        rst_nx = 1'b1;
        #1;
        check("async_rst_led", LED, 8'h00);
        check("async_rst_clip", {7'd0, clip}, 8'h00);
        @(posedge clk);
        model_edge();
        idle(2);
        rst_nx = 1'b0;
        step(1'b1, 16'h0080, 16'h0000);
        idle(6);

        // randomized traffic with varying density and occasional mode flips
        for (int seg = 0; seg < 30; seg++) begin
            int dens;
            dens = $urandom_range(0, 4);
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 40) == 0) mode_nx = ~mode_nx;
                if ($urandom_range(0, 4) < dens) step(1'b1, rnd_samp(), rnd_samp());
                else step(1'b0, rnd_samp(), rnd_samp());
            end
        end
        idle(5);
        @(posedge clk);
        #2;
        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
